// File: rtl/audio_voice_mixer.sv
// audio_voice_mixer
//   N-voice stereo mixer feeding Audio_Controller. Once per SAMPLE_DIV cycles the
//   voice inputs are snapshotted, then summed one voice per cycle (gain + pan) into
//   wide left/right accumulators. The sum is rescaled, saturated and queued in a
//   small show-ahead frame FIFO that drains through audio_out_allowed/write_audio_out.
// Ports
//   CLOCK_50, reset          clock, synchronous active-high reset
//   voice_samples            signed sample per voice, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   voice_enable             per-voice contribute enable
//   voice_gain               unsigned Q1.(GAIN_W-1) gain per voice
//   voice_pan                2b per voice: 00 both, 01 left, 10 right, 11 muted
//   clip_clear               pulse, clears clip_flag
//   audio_out_allowed        sink can accept a frame
//   left/right_channel_audio_out  FIFO head frame (0 when empty)
//   write_audio_out          frame transferred (popped) this cycle
//   fifo_level               frames queued
//   clip_flag                sticky saturation indicator
//   dropped_frames           saturating count of frames lost to a full FIFO
module audio_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 32,
  parameter int GAIN_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic [NUM_VOICES*SAMPLE_W-1:0]   voice_samples,
  input  logic [NUM_VOICES-1:0]            voice_enable,
  input  logic [NUM_VOICES*GAIN_W-1:0]     voice_gain,
  input  logic [NUM_VOICES*2-1:0]          voice_pan,
  input  logic                             clip_clear,
  input  logic                             audio_out_allowed,
  output logic [SAMPLE_W-1:0]              left_channel_audio_out,
  output logic [SAMPLE_W-1:0]              right_channel_audio_out,
  output logic                             write_audio_out,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             clip_flag,
  output logic [7:0]                       dropped_frames
);
  localparam int PW    = SAMPLE_W + GAIN_W + 1;
  localparam int AW    = PW + $clog2(NUM_VOICES);
  localparam int IW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CW    = $clog2(SAMPLE_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CLIP, S_PUSH} state_t;

  state_t state, state_nxt;

  // sample-period tick
  logic [CW-1:0] tick_cnt;
  logic          tick;
  assign tick = (tick_cnt == CW'(SAMPLE_DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CW'(1);
  end

  // FSM
  logic [IW-1:0] idx;
  logic          last_voice;
  logic          start;
  assign last_voice = (idx == IW'(NUM_VOICES - 1));
  assign start      = (state == S_IDLE) && tick;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick) state_nxt = S_ACCUM;
      S_ACCUM: if (last_voice) state_nxt = S_CLIP;
      S_CLIP:  state_nxt = S_PUSH;
      S_PUSH:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // snapshot: data-only registers, no reset needed
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] snap_samp;
  logic [NUM_VOICES-1:0][GAIN_W-1:0]   snap_gain;
  logic [NUM_VOICES-1:0][1:0]          snap_pan;
  logic [NUM_VOICES-1:0]               snap_en;

  always_ff @(posedge CLOCK_50) begin
    if (start) begin
      snap_samp <= voice_samples;
      snap_gain <= voice_gain;
      snap_pan  <= voice_pan;
      snap_en   <= voice_enable;
    end
  end

  // one shared multiplier, one voice per cycle
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic                 add_l, add_r;
  assign prod     = PW'($signed(snap_samp[idx])) * PW'($signed({1'b0, snap_gain[idx]}));
  assign prod_ext = AW'(prod);
  // pan bit1 set excludes left, bit0 set excludes right; 11 mutes
  assign add_l    = snap_en[idx] & ~snap_pan[idx][1];
  assign add_r    = snap_en[idx] & ~snap_pan[idx][0];

  logic signed [AW-1:0] acc_l, acc_r;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      idx   <= '0;
      acc_l <= '0;
      acc_r <= '0;
    end else if (start) begin
      idx   <= '0;
      acc_l <= '0;
      acc_r <= '0;
    end else if (state == S_ACCUM) begin
      idx <= idx + IW'(1);
      if (add_l) acc_l <= acc_l + prod_ext;
      if (add_r) acc_r <= acc_r + prod_ext;
    end
  end

  // rescale (floor) and saturate; returns {clipped, value}
  function automatic logic [SAMPLE_W:0] saturate(input logic signed [AW-1:0] v);
    logic [AW-SAMPLE_W:0] hi;
    hi = v[AW-1:SAMPLE_W-1];
    if ((&hi) || !(|hi)) return {1'b0, v[SAMPLE_W-1:0]};
    else if (v[AW-1])    return {1'b1, 1'b1, {(SAMPLE_W-1){1'b0}}};
    else                 return {1'b1, 1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  logic signed [AW-1:0] sh_l, sh_r;
  logic [SAMPLE_W:0]    sat_l, sat_r;
  assign sh_l  = acc_l >>> (GAIN_W - 1);
  assign sh_r  = acc_r >>> (GAIN_W - 1);
  assign sat_l = saturate(sh_l);
  assign sat_r = saturate(sh_r);

  logic [SAMPLE_W-1:0] frame_l, frame_r;
  logic                clip_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame_l <= '0;
      frame_r <= '0;
      clip_q  <= 1'b0;
    end else begin
      if (state == S_CLIP) begin
        frame_l <= sat_l[SAMPLE_W-1:0];
        frame_r <= sat_r[SAMPLE_W-1:0];
      end
      // a new saturation beats a simultaneous clear
      if ((state == S_CLIP) && (sat_l[SAMPLE_W] || sat_r[SAMPLE_W])) clip_q <= 1'b1;
      else if (clip_clear)                                           clip_q <= 1'b0;
    end
  end

  // frame FIFO, show-ahead
  logic [FIFO_DEPTH-1:0][2*SAMPLE_W-1:0] fifo_mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [7:0]       drop_cnt;
  logic             empty, full, pop, push, drop;

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign pop   = audio_out_allowed & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push  = (state == S_PUSH) & (~full | pop);
  assign drop  = (state == S_PUSH) & full & ~pop;

  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_mem[wr_ptr] <= {frame_l, frame_r};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // outputs forced to 0 while reset is held, even before state has cleared
  logic [2*SAMPLE_W-1:0] head;
  logic                  hide;
  assign head = fifo_mem[rd_ptr];
  assign hide = reset | empty;

  assign left_channel_audio_out  = hide ? '0 : head[2*SAMPLE_W-1:SAMPLE_W];
  assign right_channel_audio_out = hide ? '0 : head[SAMPLE_W-1:0];
  assign write_audio_out         = pop & ~reset;
  assign fifo_level              = reset ? '0 : level;
  assign clip_flag               = clip_q & ~reset;
  assign dropped_frames          = reset ? '0 : drop_cnt;

endmodule
